// File: rtl/ram_dual_pkg.sv
// Shared constants and helpers for the parametrised simple dual-port RAM.
// byte_merge works on a fixed maximum width so one function serves every instance width.
package ram_dual_pkg;

    localparam int unsigned RDW_OLD = 0;
    localparam int unsigned RDW_NEW = 1;

    localparam int unsigned MaxW    = 256;
    localparam int unsigned MaxIdxW = 8;

    typedef logic [MaxW-1:0] word_t;

    // Lane i of the result takes new_w when be_w[i] is set, otherwise old_w.
    function automatic word_t byte_merge(input word_t       old_w,
                                         input word_t       new_w,
                                         input word_t       be_w,
                                         input int unsigned byte_w);
        word_t r;
        r = old_w;
        for (int unsigned i = 0; i < MaxW; i++) begin
            if (be_w[MaxIdxW'(i / byte_w)]) begin
                r[MaxIdxW'(i)] = new_w[MaxIdxW'(i)];
            end
        end
        return r;
    endfunction

    function automatic bit lanes_ok(input int unsigned dw, input int unsigned bw);
        return (bw != 0) && (dw != 0) && ((dw % bw) == 0) && (dw <= MaxW);
    endfunction

    function automatic bit depth_ok(input int unsigned depth, input int unsigned aw);
        return (depth >= 1) && (aw >= 1) && (aw < 32) && (64'(depth) <= (64'd1 << aw));
    endfunction

endpackage

// File: rtl/ram_dual_out_stage.sv
// Optional second read register: delays read data and its valid pulse by one cycle.
module ram_dual_out_stage
    import ram_dual_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o
);

    logic [DATA_WIDTH-1:0] data_d, data_q;
    logic                  valid_d, valid_q;

    always_comb begin
        data_d  = valid_i ? data_i : data_q;
        valid_d = valid_i;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/ram_dual_param.sv
// Single-clock simple dual-port RAM with byte-lane writes, selectable read-during-write
// policy, optional output register, read-valid pulse and sticky out-of-range flag.
module ram_dual_param
    import ram_dual_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BYTE_W     = 8,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned RDW_MODE   = 0,
    parameter int unsigned OUT_REG    = 0
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [DATA_WIDTH-1:0]        data,
    input  logic [ADDR_WIDTH-1:0]        write_addr,
    input  logic                         we,
    input  logic [DATA_WIDTH/BYTE_W-1:0] be,
    input  logic [ADDR_WIDTH-1:0]        read_addr,
    input  logic                         re,
    output logic [DATA_WIDTH-1:0]        q,
    output logic                         q_valid,
    output logic                         addr_err
);

    localparam logic [ADDR_WIDTH:0] DepthLim = (ADDR_WIDTH + 1)'(DEPTH);

    if (!lanes_ok(DATA_WIDTH, BYTE_W)) begin : g_bad_lanes
        $error("ram_dual_param: DATA_WIDTH must be a non-zero multiple of BYTE_W");
    end
    if (!depth_ok(DEPTH, ADDR_WIDTH)) begin : g_bad_depth
        $error("ram_dual_param: DEPTH must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  wr_in_range, rd_in_range;
    logic                  wr_oob, rd_oob, rdw_bypass;
    logic [DATA_WIDTH-1:0] wr_old, wr_word, rd_raw, rd_word;

    logic [DATA_WIDTH-1:0] rd_data_d, rd_data_q;
    logic                  rd_valid_d, rd_valid_q;
    logic                  err_d, err_q;

    assign wr_in_range = {1'b0, write_addr} < DepthLim;
    assign rd_in_range = {1'b0, read_addr} < DepthLim;
    assign wr_oob      = we && !wr_in_range;
    assign rd_oob      = re && !rd_in_range;

    always_comb begin
        wr_old  = wr_in_range ? mem_q[write_addr] : '0;
        wr_word = DATA_WIDTH'(byte_merge(word_t'(wr_old), word_t'(data), word_t'(be), BYTE_W));
        rd_raw  = rd_in_range ? mem_q[read_addr] : '0;
        // Same-address bypass: wr_word is exactly the merged word the write will store.
        rdw_bypass = (RDW_MODE == RDW_NEW) && we && wr_in_range && (write_addr == read_addr);
        if (!rd_in_range) begin
            rd_word = '0;
        end else if (rdw_bypass) begin
            rd_word = wr_word;
        end else begin
            rd_word = rd_raw;
        end
    end

    // Storage is not reset; the reset_n term only blocks writes while reset is held.
    always_ff @(posedge clock) begin
        if (reset_n && we && wr_in_range) begin
            mem_q[write_addr] <= wr_word;
        end
    end

    always_comb begin
        rd_data_d  = re ? rd_word : rd_data_q;
        rd_valid_d = re;
        err_d      = err_q | wr_oob | rd_oob;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        ram_dual_out_stage #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_out_stage (
            .clock  (clock),
            .reset_n(reset_n),
            .data_i (rd_data_q),
            .valid_i(rd_valid_q),
            .data_o (q),
            .valid_o(q_valid)
        );
    end else begin : g_no_out_reg
        assign q       = rd_data_q;
        assign q_valid = rd_valid_q;
    end

    assign addr_err = err_q;

endmodule

// File: tb/tb_ram_dual_param.sv
// Bench for ram_dual_param: two configurations against a word/lane-level memory model.
module tb_ram_dual_param;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    // Instance A: defaults (8 bit, depth 64, old-data RDW, latency 1)
    logic [7:0]  a_data;
    logic [5:0]  a_wa, a_ra;
    logic        a_we, a_re;
    logic [0:0]  a_be;
    logic [7:0]  a_q;
    logic        a_v, a_err;

    // Instance B: 32 bit, depth 48, new-data RDW, latency 2
    logic [31:0] b_data;
    logic [5:0]  b_wa, b_ra;
    logic        b_we, b_re;
    logic [3:0]  b_be;
    logic [31:0] b_q;
    logic        b_v, b_err;

    ram_dual_param u_a (
        .clock(clock), .reset_n(reset_n), .data(a_data), .write_addr(a_wa), .we(a_we),
        .be(a_be), .read_addr(a_ra), .re(a_re), .q(a_q), .q_valid(a_v), .addr_err(a_err)
    );

    ram_dual_param #(
        .DATA_WIDTH(32), .BYTE_W(8), .ADDR_WIDTH(6), .DEPTH(48), .RDW_MODE(1), .OUT_REG(1)
    ) u_b (
        .clock(clock), .reset_n(reset_n), .data(b_data), .write_addr(b_wa), .we(b_we),
        .be(b_be), .read_addr(b_ra), .re(b_re), .q(b_q), .q_valid(b_v), .addr_err(b_err)
    );

    int n_total = 0;
    int n_pass  = 0;
    bit cmp_en  = 1'b0;

    // Model state, index 0 = A, 1 = B
    logic [31:0] mm [2][64];
    logic [3:0]  mk [2][64];
    logic [31:0] eq [2];
    bit          ev [2], ek [2], err_m [2];
    logic [31:0] stq [2];
    bit          stv [2], stk [2];

    function automatic int m_lanes(int i); return (i == 0) ? 1 : 4; endfunction
    function automatic int m_depth(int i); return (i == 0) ? 64 : 48; endfunction
    function automatic int m_rdw(int i); return (i == 0) ? 0 : 1; endfunction
    function automatic int m_lat(int i); return (i == 0) ? 1 : 2; endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            eq[i] = '0; ek[i] = 1'b1; ev[i] = 1'b0; err_m[i] = 1'b0;
            stv[i] = 1'b0; stq[i] = '0; stk[i] = 1'b1;
        end
    endtask

    task automatic model_edge(input int i, input bit we, input int wa, input logic [31:0] d,
                              input logic [3:0] be, input bit re, input int ra);
        logic [31:0] rv;
        logic [3:0]  rk, full;
        bit          rvk;
        int          nb;
        if (!reset_n) return;
        nb   = m_lanes(i);
        full = (nb == 4) ? 4'hF : 4'h1;
        rv   = '0;
        rvk  = 1'b1;
        if (re) begin
            if (ra >= m_depth(i)) begin
                err_m[i] = 1'b1;
            end else begin
                rv = mm[i][ra];
                rk = mk[i][ra];
                if (m_rdw(i) == 1 && we && wa == ra) begin
                    for (int l = 0; l < nb; l++) begin
                        if (be[l]) begin rv[l*8 +: 8] = d[l*8 +: 8]; rk[l] = 1'b1; end
                    end
                end
                rvk = ((rk & full) == full);
            end
        end
        if (we) begin
            if (wa >= m_depth(i)) begin
                err_m[i] = 1'b1;
            end else begin
                for (int l = 0; l < nb; l++) begin
                    if (be[l]) begin mm[i][wa][l*8 +: 8] = d[l*8 +: 8]; mk[i][wa][l] = 1'b1; end
                end
            end
        end
        if (m_lat(i) == 1) begin
            ev[i] = re;
            if (re) begin eq[i] = rv; ek[i] = rvk; end
        end else begin
            ev[i] = stv[i];
            if (stv[i]) begin eq[i] = stq[i]; ek[i] = stk[i]; end
            stv[i] = re;
            if (re) begin stq[i] = rv; stk[i] = rvk; end
        end
    endtask

    // Drive one cycle on instance inst (the other idles), advance the model at the edge.
    task automatic cyc(input int inst, input bit we, input int wa, input logic [31:0] d,
                       input logic [3:0] be, input bit re, input int ra);
        a_we = 1'b0; a_re = 1'b0; a_be = '0; a_data = '0; a_wa = '0; a_ra = '0;
        b_we = 1'b0; b_re = 1'b0; b_be = '0; b_data = '0; b_wa = '0; b_ra = '0;
        if (inst == 0) begin
            a_we = we; a_wa = 6'(wa); a_data = d[7:0]; a_be = be[0:0]; a_re = re; a_ra = 6'(ra);
        end else begin
            b_we = we; b_wa = 6'(wa); b_data = d; b_be = be; b_re = re; b_ra = 6'(ra);
        end
        @(posedge clock);
        model_edge(0, inst == 0 && we, wa, d, be, inst == 0 && re, ra);
        model_edge(1, inst == 1 && we, wa, d, be, inst == 1 && re, ra);
        #1;
    endtask

    task automatic idle();
        cyc(0, 1'b0, 0, 32'h0, 4'h0, 1'b0, 0);
    endtask

    always @(negedge clock) begin
        if (cmp_en) begin
            chk("a_q_valid", 32'(a_v), 32'(ev[0]));
            chk("a_addr_err", 32'(a_err), 32'(err_m[0]));
            if (ek[0]) chk("a_q", 32'(a_q), eq[0] & 32'hFF);
            chk("b_q_valid", 32'(b_v), 32'(ev[1]));
            chk("b_addr_err", 32'(b_err), 32'(err_m[1]));
            if (ek[1]) chk("b_q", b_q, eq[1]);
        end
    end

    initial begin
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 64; j++) begin mm[i][j] = '0; mk[i][j] = '0; end
        a_we = 1'b0; a_re = 1'b0; a_be = '0; a_data = '0; a_wa = '0; a_ra = '0;
        b_we = 1'b0; b_re = 1'b0; b_be = '0; b_data = '0; b_wa = '0; b_ra = '0;
        reset_n = 1'b0;
        model_reset();
        #2;
        chk("reset_a_q", 32'(a_q), 32'h0);
        chk("reset_a_valid", 32'(a_v), 32'h0);
        chk("reset_b_q", b_q, 32'h0);
        chk("reset_b_err", 32'(b_err), 32'h0);
        @(posedge clock); @(posedge clock); #3;
        reset_n = 1'b1;
        cmp_en  = 1'b1;

        // 1: write A5 @3, read @3 next cycle, latency 1, single-cycle pulse
        cyc(0, 1'b1, 3, 32'hA5, 4'h1, 1'b0, 0);
        cyc(0, 1'b0, 0, 32'h0, 4'h0, 1'b1, 3);
        chk("t1_q", 32'(a_q), 32'hA5);
        chk("t1_valid", 32'(a_v), 32'h1);
        chk("t1_model", eq[0], 32'hA5);
        idle();
        chk("t1_valid_drop", 32'(a_v), 32'h0);
        chk("t1_q_hold", 32'(a_q), 32'hA5);

        // 2: byte-lane merge on 32-bit instance
        cyc(1, 1'b1, 10, 32'h11223344, 4'hF, 1'b0, 0);
        cyc(1, 1'b1, 10, 32'hAABBCCDD, 4'b0101, 1'b0, 0);
        cyc(1, 1'b0, 0, 32'h0, 4'h0, 1'b1, 10);
        idle();
        chk("t2_q", b_q, 32'h11BB33DD);
        chk("t2_model", eq[1], 32'h11BB33DD);

        // 3: same-address read-during-write, old policy (A) and new policy (B)
        cyc(0, 1'b1, 5, 32'h01, 4'h1, 1'b0, 0);
        cyc(0, 1'b1, 5, 32'hFF, 4'h1, 1'b1, 5);
        chk("t3_old_q", 32'(a_q), 32'h01);
        cyc(0, 1'b0, 0, 32'h0, 4'h0, 1'b1, 5);
        chk("t3_after_q", 32'(a_q), 32'hFF);
        cyc(1, 1'b1, 5, 32'h01, 4'hF, 1'b0, 0);
        cyc(1, 1'b1, 5, 32'hFF, 4'hF, 1'b1, 5);
        idle();
        chk("t3_new_q", b_q, 32'hFF);
        cyc(1, 1'b1, 5, 32'h0000AB00, 4'b0010, 1'b1, 5);
        idle();
        chk("t3_merge_q", b_q, 32'h0000ABFF);

        // 4: back-to-back reads with output register
        for (int k = 0; k < 4; k++) cyc(1, 1'b1, k, 32'h10 + k, 4'hF, 1'b0, 0);
        idle();
        cyc(1, 1'b0, 0, 32'h0, 4'h0, 1'b1, 0);
        chk("t4_lat_valid0", 32'(b_v), 32'h0);
        cyc(1, 1'b0, 0, 32'h0, 4'h0, 1'b1, 1);
        chk("t4_first_q", b_q, 32'h10);
        cyc(1, 1'b0, 0, 32'h0, 4'h0, 1'b1, 2);
        cyc(1, 1'b0, 0, 32'h0, 4'h0, 1'b1, 3);
        chk("t4_third_q", b_q, 32'h12);
        idle();
        chk("t4_last_q", b_q, 32'h13);
        chk("t4_last_valid", 32'(b_v), 32'h1);
        idle();
        chk("t4_end_valid", 32'(b_v), 32'h0);

        // 5: out-of-range write/read on depth-48 instance, no wrap to address 2
        cyc(1, 1'b1, 2, 32'h22, 4'hF, 1'b0, 0);
        chk("t5_err_clear", 32'(b_err), 32'h0);
        cyc(1, 1'b1, 50, 32'hDEADBEEF, 4'hF, 1'b0, 0);
        chk("t5_err_set", 32'(b_err), 32'h1);
        cyc(1, 1'b0, 0, 32'h0, 4'h0, 1'b1, 2);
        idle();
        chk("t5_nowrap_q", b_q, 32'h22);
        cyc(1, 1'b0, 0, 32'h0, 4'h0, 1'b1, 50);
        idle();
        chk("t5_oob_q", b_q, 32'h0);
        chk("t5_oob_valid", 32'(b_v), 32'h1);
        idle(); idle();
        chk("t5_err_sticky", 32'(b_err), 32'h1);
        chk("t5_a_err", 32'(a_err), 32'h0);

        // 6: reset mid-read, contents retained, write under reset ignored
        cyc(1, 1'b1, 7, 32'h3C, 4'hF, 1'b0, 0);
        cyc(1, 1'b0, 0, 32'h0, 4'h0, 1'b1, 7);
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("t6_rst_q", b_q, 32'h0);
        chk("t6_rst_valid", 32'(b_v), 32'h0);
        chk("t6_rst_err", 32'(b_err), 32'h0);
        cyc(1, 1'b1, 7, 32'hFF, 4'hF, 1'b1, 7);
        idle();
        #2;
        reset_n = 1'b1;
        idle();
        chk("t6_no_stale_valid", 32'(b_v), 32'h0);
        idle();
        cyc(1, 1'b0, 0, 32'h0, 4'h0, 1'b1, 7);
        idle();
        chk("t6_retained_q", b_q, 32'h3C);
        chk("t6_retained_valid", 32'(b_v), 32'h1);
        idle(); idle();

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
